// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
// Consumes the EX/MEM register, runs the data-memory req/ack handshake for
// loads and stores, stalls the front of the pipeline while an access is
// outstanding, and presents a registered MEM/WB bundle (bubbles while stalled).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; non-memory ops retire in one cycle
// BUSY  | dmem_req held high, waiting for dmem_ack or the abort timeout
module mem_stage #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   MEM_in,
  input  logic [1:0]   WB_in,
  input  logic [N-1:0] Alu_in,
  input  logic [N-1:0] Writedata_in,
  input  logic [4:0]   loadreg_in,
  output logic         stall,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic [N-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic [1:0]   WB_out,
  output logic [N-1:0] Readdata,
  output logic [N-1:0] Alu_out,
  output logic [4:0]   loadregout,
  output logic         err
);

  // Counter only ever reaches TIMEOUT-1, so this width leaves headroom and
  // the counter is never allowed to wrap.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          last;
  logic          unused_branch;

  // Branch bit travels with the control bundle but has no role in this stage.
  assign unused_branch = MEM_in[2];

  // Any read or write needs the handshake; read+write together is a write.
  assign acc  = MEM_in[1] | MEM_in[0];
  assign last = (cnt == CNT_LAST);

  // Stall is released in the retiring cycle (ack or abort) so the next
  // instruction enters on the same edge, giving no dead cycles.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      if (state == IDLE) stall = acc;
      else               stall = !dmem_ack && !last;
    end
  end

  // Handshake FSM together with the registered MEM/WB bundle and memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      WB_out     <= '0;
      Readdata   <= '0;
      Alu_out    <= '0;
      loadregout <= '0;
      err        <= 1'b0;
    end else begin
      // Inputs are held stable during a stall, so tracking them every edge
      // leaves these fields correct when the instruction finally retires.
      Alu_out    <= Alu_in;
      loadregout <= loadreg_in;
      case (state)
        IDLE: begin
          Readdata <= '0;
          if (acc) begin
            WB_out     <= 2'b00;
            dmem_req   <= 1'b1;
            dmem_we    <= MEM_in[0];
            dmem_addr  <= Alu_in;
            dmem_wdata <= Writedata_in;
            cnt        <= '0;
            state      <= BUSY;
          end else begin
            WB_out <= WB_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            // An ack in the final allowed cycle still completes normally.
            WB_out   <= WB_in;
            Readdata <= dmem_we ? '0 : dmem_rdata;
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (last) begin
            // Abort: squash the instruction and flag the lost access.
            err      <= 1'b1;
            WB_out   <= 2'b00;
            Readdata <= '0;
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            WB_out   <= 2'b00;
            Readdata <= '0;
            cnt      <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline and the consumer of the EX/MEM pipeline register. Takes the registered MEM/WB control bits, ALU result, store data and destination register, and runs the data-memory req/ack handshake for loads and stores. Stalls the front of the pipeline while an access is outstanding. Presents a registered MEM/WB bundle to write-back, inserting bubbles during stalls.

## Interface
- N, 32, datapath width
- TIMEOUT, 15, max BUSY cycles without ack before abort; legal range >= 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MEM_in  in  3  [2] Branch (ignored here), [1] MemRead, [0] MemWrite
- WB_in  in  2  [1] RegWrite, [0] MemtoReg
- Alu_in  in  N  ALU result; memory byte address for loads/stores
- Writedata_in  in  N  store data
- loadreg_in  in  5  destination register
- stall  out  1  freeze EX/MEM register and all earlier stages
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, 0 = read, registered
- dmem_addr  out  N  registered copy of Alu_in
- dmem_wdata  out  N  registered copy of Writedata_in
- dmem_rdata  in  N  read data, valid in the dmem_ack cycle
- dmem_ack  in  1  single-cycle completion strobe
- WB_out  out  2  registered WB control
- Readdata  out  N  registered load data
- Alu_out  out  N  registered ALU result
- loadregout  out  5  registered destination register
- err  out  1  sticky timeout flag

## Operation
- Access type: `acc = MEM_in[1] | MEM_in[0]`. If both bits are set, the access is a write and no error is raised.
- FSM has two states, IDLE and BUSY.
- IDLE, `acc = 0`:
  - stall = 0.
  - Next edge loads WB_out, Alu_out and loadregout from the inputs; Readdata loads 0.
- IDLE, `acc = 1`:
  - stall = 1.
  - Next edge: dmem_req = 1, dmem_we = MEM_in[0], dmem_addr and dmem_wdata captured, counter cleared, go to BUSY.
  - WB_out loads 00 (bubble).
- BUSY, `dmem_ack = 0`:
  - stall = 1, counter += 1, WB_out loads 00 each edge.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata held.
- BUSY, `dmem_ack = 1`:
  - stall = 0.
  - Next edge loads WB_out, Alu_out and loadregout from the inputs, which are unchanged because of the stall.
  - Readdata loads dmem_rdata for a read and 0 for a write.
  - dmem_req = 0, go to IDLE.
- BUSY with counter == TIMEOUT - 1 and no ack:
  - stall = 0.
  - Next edge: err = 1 (sticky until rst), dmem_req = 0, instruction squashed (WB_out = 00, Readdata = 0), go to IDLE.
  - An ack in that same cycle wins over the timeout: normal completion, err unchanged.
- dmem_ack is ignored outside BUSY.
- Upstream guarantee: while stall = 1, all *_in inputs are held stable.
- Counter width is clog2(TIMEOUT+1); it never wraps.

## Timing
- Reset (async, immediate) sets:
  - FSM to IDLE, counter 0
  - dmem_req, dmem_we, dmem_addr, dmem_wdata to 0
  - WB_out, Readdata, Alu_out, loadregout to 0
  - err to 0
  - stall forced to 0 while rst = 1
- Reset during BUSY drops dmem_req asynchronously and abandons the access. No completion is produced and err is not set.
- Non-memory instruction: 1-cycle latency to the MEM/WB outputs, no stall.
- Load/store with ack k cycles after dmem_req rises (k >= 0, ack in the first BUSY cycle being k = 0):
  - stall high for k+1 cycles
  - results visible k+2 edges after arrival
- Per access, dmem_req is high for exactly k+1 cycles, or TIMEOUT cycles on abort.
- Back-to-back loads: the second load enters IDLE on the edge that retires the first and raises stall in that cycle. There are no dead cycles beyond the handshake.
- stall is combinational from state, acc and dmem_ack. All other outputs are registered.

## Test plan
- Reset mid-BUSY: raise rst while dmem_req = 1 -> dmem_req, WB_out and err are 0 immediately; after release, FSM is IDLE and stall = 0.
- ALU op: MEM_in = 000, WB_in = 10, Alu_in = 0x0000_0040, loadreg_in = 5 -> next edge gives WB_out = 10, Alu_out = 0x40, loadregout = 5, Readdata = 0, stall never asserted.
- Load with ack after 2 BUSY cycles: MEM_in = 010, Alu_in = 0x100, dmem_rdata = 0xDEAD_BEEF -> stall high 3 cycles, WB_out = 00 during the stall, then Readdata = 0xDEADBEEF and WB_out = WB_in.
- Store with ack in the first BUSY cycle: MEM_in = 001, Writedata_in = 0x1234 -> dmem_we = 1, dmem_wdata = 0x1234, dmem_req high 1 cycle, stall high 1 cycle, Readdata = 0.
- Timeout with TIMEOUT = 4 and no ack -> dmem_req high 4 cycles, err = 1 and sticky, that instruction's WB_out = 00; a following ALU op proceeds normally.
- Ack coincident with the timeout cycle -> normal completion with dmem_rdata captured and err stays 0. MEM_in = 011 -> treated as a write.
